multichannel_delay_line: RTL
============================

Name: multichannel_delay_line

Overview:
- Parametrised successor to the single-channel delay path. One mono input sample stream is written into a shared circular buffer, and CHANNELS delayed, gain-scaled taps are read back, one per output speaker.
- Runs from the system clock and advances one frame per sample_strobe pulse, so no derived sample clock is needed.
- Per-channel delay (samples) and gain come from the upstream geometry logic (distance/theta mapping).

Parameters:
- CHANNELS, 2: number of output taps (1..8).
- WIDTH, 16: signed sample width.
- DEPTH_LOG2, 10: buffer depth is 2^DEPTH_LOG2 samples; maximum delay is 2^DEPTH_LOG2-1.
- GAIN_W, 8: unsigned gain width; unity gain is 2^(GAIN_W-1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sample_strobe  in  1  one-cycle pulse per audio sample (44.1 kHz)
- signal_in  in  WIDTH  signed input sample; sampled in the cycle sample_strobe is accepted
- delay  in  CHANNELS*DEPTH_LOG2  per-channel delay in samples; channel k occupies slice k
- gain  in  CHANNELS*GAIN_W  per-channel unsigned gain; channel k occupies slice k
- signal_out  out  CHANNELS*WIDTH  signed delayed, scaled samples; channel k occupies slice k
- out_valid  out  1  one-cycle pulse when signal_out updates
- busy  out  1  high while clearing or processing a frame
- overrun  out  1  sticky flag: a strobe arrived while busy

Behaviour:
- Reset, applied on any cycle and aborting any frame in progress:
  - signal_out=0, out_valid=0, overrun=0, write pointer=0, effective delays=0.
  - FSM enters CLEAR.
- Memory: single-port synchronous RAM, 2^DEPTH_LOG2 x WIDTH, with 1-cycle read latency.
- CLEAR state:
  - Writes 0 to every address, 2^DEPTH_LOG2 cycles in total; busy=1.
  - Strobes during CLEAR are ignored and do not set overrun.
  - Then goes to IDLE.
- FSM sequence: IDLE -> WRITE -> (READ_k -> CALC_k) for k=0..CHANNELS-1 -> DONE -> IDLE.
- IDLE: busy=0. When sample_strobe=1, latch signal_in, all delay slices and all gain slices, then go to WRITE.
- WRITE: write the latched sample to address wr_ptr; update effective delays (see Optional Feature).
- READ_k: address = (wr_ptr - eff_delay[k]) mod 2^DEPTH_LOG2, with natural wrap-around.
  - Delay 0 returns the sample written in this same frame.
- CALC_k:
  - prod = rdata (signed) * gain[k] (unsigned, zero-extended).
  - scaled = prod >>> (GAIN_W-1), an arithmetic shift that rounds toward minus infinity.
  - Saturate scaled to [-2^(WIDTH-1), 2^(WIDTH-1)-1] and store it in a staging register.
- DONE: copy all staging registers to signal_out simultaneously; out_valid=1 for this one cycle; wr_ptr increments, wrapping at 2^DEPTH_LOG2.
- Latency: out_valid is asserted exactly 2*CHANNELS+2 cycles after the cycle in which the strobe was accepted.
  - signal_out holds its value between frames.
- busy is 1 from the WRITE cycle through the DONE cycle inclusive.
- A strobe while busy (not in CLEAR):
  - The strobe is dropped and overrun is set to 1.
  - The current frame completes unaffected.
- Input changes to delay, gain or signal_in mid-frame do not affect the current frame.

Optional Feature:
- Macro: DELAY_SMOOTH_EN.
- Defined: in each WRITE, eff_delay[k] moves toward the latched target by at most 1 sample (+1, -1 or hold). This avoids clicks when distance or angle changes.
- Undefined: eff_delay[k] equals the latched target immediately in WRITE.

Test Plan:
- Reset/clear: pulse rst for 1 cycle -> busy=1 for exactly 2^DEPTH_LOG2 cycles, signal_out=0, out_valid=0; a strobe issued mid-clear is ignored and overrun stays 0.
- Impulse: CHANNELS=2, delay={5,0}, gain=128 both; input 1000 in frame 0 then 0 -> ch0 outputs 1000 in frame 0; ch1 outputs 1000 in frame 5 and 0 in every other frame; out_valid arrives 6 cycles after each strobe.
- Gain/saturation: delay 0.
  - Input 20000 with gain 255 -> 32767.
  - Input -20000 with gain 255 -> -32768.
  - Input -3 with gain 64 -> -2.
  - Input 1000 with gain 0 -> 0.
- Wrap: DEPTH_LOG2=4, delay 15, input ramp n=0..39 -> output equals n-15 for n>=15 and 0 before that, with correct behaviour across two pointer wraps.
- Overrun: strobes on two consecutive cycles -> second is dropped, overrun=1 and stays 1; first frame output is correct; rst clears overrun.
- Smoothing: delay target stepped 0 -> 4 with an impulse train.
  - With DELAY_SMOOTH_EN: eff_delay becomes 1,2,3,4 over four frames.
  - Without it: the delay is 4 in the very next frame.

Source files
------------

// File: rtl/multichannel_delay_line.sv
// Shared circular-buffer delay line: one mono input, CHANNELS delayed and gain-scaled taps.
// Optional macro DELAY_SMOOTH_EN slews each effective delay by at most one sample per frame.
module multichannel_delay_line #(
   parameter int CHANNELS   = 2,
   parameter int WIDTH      = 16,
   parameter int DEPTH_LOG2 = 10,
   parameter int GAIN_W     = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            sample_strobe,
   input  logic signed [WIDTH-1:0]         signal_in,
   input  logic [CHANNELS*DEPTH_LOG2-1:0]  delay,
   input  logic [CHANNELS*GAIN_W-1:0]      gain,
   output logic [CHANNELS*WIDTH-1:0]       signal_out,
   output logic                            out_valid,
   output logic                            busy,
   output logic                            overrun,
   output logic [2:0]                      dbg_state
);

   localparam int DEPTH  = 2 ** DEPTH_LOG2;
   localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int PROD_W = WIDTH + GAIN_W + 1;
   localparam logic signed [PROD_W-1:0] MAX_V = {{(PROD_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [PROD_W-1:0] MIN_V = {{(PROD_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_WRITE, S_READ, S_CALC, S_DONE} state_t;
   state_t state_q, state_d;

   logic [DEPTH_LOG2-1:0]   wr_ptr, clr_addr, mem_addr;
   logic [CH_W-1:0]         ch;
   logic                    last_ch;
   logic signed [WIDTH-1:0] sample_lat;
   logic [DEPTH_LOG2-1:0]   delay_lat [CHANNELS];
   logic [GAIN_W-1:0]       gain_lat  [CHANNELS];
   logic [DEPTH_LOG2-1:0]   eff_delay [CHANNELS];
   logic signed [WIDTH-1:0] stage      [CHANNELS];
   logic signed [WIDTH-1:0] stage_next [CHANNELS];
   logic [WIDTH-1:0]        mem [DEPTH];
   logic [WIDTH-1:0]        rdata, mem_wdata;
   logic                    mem_we;
   logic signed [WIDTH-1:0] rdata_s;
   logic signed [GAIN_W:0]  gain_s;
   logic signed [PROD_W-1:0] prod, scaled;
   logic signed [WIDTH-1:0] sat;

   assign last_ch   = (ch == CH_W'(CHANNELS - 1));
   assign busy      = (state_q != S_IDLE);
   assign dbg_state = state_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_CLEAR: if (clr_addr == '1) state_d = S_IDLE;
         S_IDLE:  if (sample_strobe) state_d = S_WRITE;
         S_WRITE: state_d = S_READ;
         S_READ:  state_d = S_CALC;
         S_CALC:  state_d = last_ch ? S_DONE : S_READ;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_CLEAR;
      endcase
   end

   // Single RAM port shared by clear, sample write and tap reads.
   always_comb begin
      mem_we    = 1'b0;
      mem_wdata = sample_lat;
      mem_addr  = wr_ptr - eff_delay[ch];
      case (state_q)
         S_CLEAR: begin
            mem_we    = 1'b1;
            mem_wdata = '0;
            mem_addr  = clr_addr;
         end
         S_WRITE: begin
            mem_we   = 1'b1;
            mem_addr = wr_ptr;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      rdata <= mem[mem_addr];
   end

   // Signed sample times zero-extended gain; >>> floors toward minus infinity.
   always_comb begin
      rdata_s = rdata;
      gain_s  = {1'b0, gain_lat[ch]};
      prod    = PROD_W'(rdata_s) * PROD_W'(gain_s);
      scaled  = prod >>> (GAIN_W - 1);
      if (scaled > MAX_V)      sat = MAX_V[WIDTH-1:0];
      else if (scaled < MIN_V) sat = MIN_V[WIDTH-1:0];
      else                     sat = scaled[WIDTH-1:0];
      for (int k = 0; k < CHANNELS; k++) stage_next[k] = stage[k];
      stage_next[ch] = sat;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_CLEAR;
         clr_addr   <= '0;
         wr_ptr     <= '0;
         ch         <= '0;
         sample_lat <= '0;
         signal_out <= '0;
         out_valid  <= 1'b0;
         overrun    <= 1'b0;
         for (int k = 0; k < CHANNELS; k++) begin
            delay_lat[k] <= '0;
            gain_lat[k]  <= '0;
            eff_delay[k] <= '0;
            stage[k]     <= '0;
         end
      end else begin
         state_q   <= state_d;
         out_valid <= 1'b0;
         if (sample_strobe && state_q != S_IDLE && state_q != S_CLEAR) overrun <= 1'b1;
         case (state_q)
            S_CLEAR: clr_addr <= clr_addr + 1'b1;
            S_IDLE: begin
               if (sample_strobe) begin
                  sample_lat <= signal_in;
                  ch         <= '0;
                  for (int k = 0; k < CHANNELS; k++) begin
                     delay_lat[k] <= delay[k*DEPTH_LOG2 +: DEPTH_LOG2];
                     gain_lat[k]  <= gain[k*GAIN_W +: GAIN_W];
                  end
               end
            end
            S_WRITE: begin
               for (int k = 0; k < CHANNELS; k++) begin
`ifdef DELAY_SMOOTH_EN
                  if (eff_delay[k] < delay_lat[k])      eff_delay[k] <= eff_delay[k] + 1'b1;
                  else if (eff_delay[k] > delay_lat[k]) eff_delay[k] <= eff_delay[k] - 1'b1;
`else
                  eff_delay[k] <= delay_lat[k];
`endif
               end
            end
            S_CALC: begin
               for (int k = 0; k < CHANNELS; k++) stage[k] <= stage_next[k];
               // Outputs load on entry to DONE so they are visible while DONE is the state.
               if (last_ch) begin
                  for (int k = 0; k < CHANNELS; k++) signal_out[k*WIDTH +: WIDTH] <= stage_next[k];
                  out_valid <= 1'b1;
               end else begin
                  ch <= ch + 1'b1;
               end
            end
            S_DONE: wr_ptr <= wr_ptr + 1'b1;
            default: ;
         endcase
      end
   end

endmodule
